alu8_sched: RTL and testbench
=============================

Name: alu8_sched

Overview:
- Sequencer/arbiter that shares one 8-bit ALU datapath between two requesters.
- Supported ops: AND, OR, XOR, ADD, SUB, NOT.
- Round-robin grant, valid/ready request handshake, registered result with response backpressure.
- Sits between requesting control blocks and the 8-bit ALU core; the core's function is implemented inline.

Parameters:
- NREQ, 2, number of requesters (fixed at 2; the grant logic is written for 2).
- W, 8, operand/result width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- req_valid  input  2  per-requester request valid.
- req_ready  output  2  per-requester accept; one-hot or zero.
- req_op  input  6  {op1[2:0], op0[2:0]}; op code per requester.
- req_a  input  16  {a1, a0} operand A per requester.
- req_b  input  16  {b1, b0} operand B per requester.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  1  requester index of current result.
- rsp_z  output  8  ALU result.
- rsp_c  output  1  ADD carry-out / SUB borrow; 0 for logic ops.
- rsp_err  output  1  illegal op code flag.
- stat_cnt  output  32  {cnt1[15:0], cnt0[15:0]}; see Optional Feature.

Behaviour:
- Reset (async, immediate): state=IDLE; last_grant=1, so requester 0 wins the first tie.
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_z=0, rsp_c=0, rsp_err=0, stat_cnt=0.
- States: IDLE, EXEC, DONE.
- IDLE:
  - grant_sel is combinational: only one valid -> that one; both valid -> the requester != last_grant; none -> no grant.
  - req_ready[grant_sel]=1 only in IDLE with a valid request.
  - On accept (req_valid[i]&req_ready[i]): latch op/a/b/id, set last_grant=i, go to EXEC.
- EXEC (1 cycle): compute the registered result into rsp_z/rsp_c/rsp_err, then go to DONE. req_ready=0.
- DONE:
  - rsp_valid=1; outputs held stable while rsp_ready=0.
  - On rsp_ready=1: rsp_valid drops next cycle, go to IDLE.
  - No accept in the same cycle as the response handoff.
- Latency: accept in cycle N -> rsp_valid in cycle N+2. Max throughput is one op per 3 cycles.
- Op codes (9-bit arithmetic internally, rsp_z=low 8 bits):
  - 000 AND; 001 OR; 010 XOR.
  - 011 ADD: rsp_c = bit 8 of a+b.
  - 100 SUB: rsp_z=a-b mod 256, rsp_c=1 when a<b (unsigned borrow).
  - 101 NOT a.
  - 110/111 illegal: rsp_z=0, rsp_c=0, rsp_err=1; still returned through DONE so the requester is released.
- Request inputs are ignored outside IDLE. A requester must hold valid/op/a/b stable until accepted.
- Withdrawal: a requester dropping valid before accept is allowed; grant recomputes.
- last_grant updates only on accept, never on a no-request cycle.
- Reset mid-operation (EXEC or DONE): the in-flight op is discarded and no response is produced.

Optional Feature:
- Macro ALU8_SCHED_STATS_EN.
- Defined:
  - cnt0/cnt1 increment on each accept for requester 0/1 respectively.
  - Counters saturate at 0xFFFF and reset to 0.
  - Illegal ops are counted too.
- Undefined: stat_cnt is tied to 0 and no counter flops are synthesized. All other behaviour is identical.

Test Plan:
- Req0 only, op=000, a=0x12, b=0x45 -> req_ready[0] in the same cycle. Two cycles later: rsp_valid=1, rsp_id=0, rsp_z=0x00, rsp_c=0. Then req0 a=0x16, b=0x55 -> rsp_z=0x14.
- Req1 ADD a=0xFF, b=0x01 -> rsp_z=0x00, rsp_c=1. SUB a=0x05, b=0x07 -> rsp_z=0xFE, rsp_c=1. SUB a=0x07, b=0x05 -> rsp_z=0x02, rsp_c=0.
- Both valid continuously for 4 ops, from reset:
  - Grant order 0,1,0,1; rsp_id matches.
  - With STATS_EN: stat_cnt=0x0002_0002.
- rsp_ready held 0 for 5 cycles in DONE -> rsp_valid, rsp_z, rsp_id stable; req_ready=0 throughout; release -> IDLE next cycle.
- Op=110, a=0xAA -> rsp_err=1, rsp_z=0x00. Next legal op (OR 0xA0|0x0F=0xAF) -> rsp_err=0.
- rst pulsed asynchronously (mid-cycle) during EXEC -> all outputs 0 immediately; no rsp_valid afterwards. Next tie is granted to requester 0.

Source files
------------

// File: rtl/alu8_sched.sv
// Two-requester round-robin scheduler around an inline 8-bit ALU (AND/OR/XOR/ADD/SUB/NOT).
// Optional per-requester accept counters enabled by defining ALU8_SCHED_STATS_EN.
module alu8_sched #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [3*NREQ-1:0]   req_op,
    input  logic [W*NREQ-1:0]   req_a,
    input  logic [W*NREQ-1:0]   req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [W-1:0]        rsp_z,
    output logic                rsp_c,
    output logic                rsp_err,
    output logic [31:0]         stat_cnt
);

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    localparam logic [2:0] OpAnd = 3'b000;
    localparam logic [2:0] OpOr  = 3'b001;
    localparam logic [2:0] OpXor = 3'b010;
    localparam logic [2:0] OpAdd = 3'b011;
    localparam logic [2:0] OpSub = 3'b100;
    localparam logic [2:0] OpNot = 3'b101;

    state_e       state_q, state_d;
    logic         last_grant_q, last_grant_d;
    logic [2:0]   op_q, op_d;
    logic [W-1:0] a_q, a_d, b_q, b_d;
    logic         id_q, id_d;
    logic [W-1:0] z_q, z_d;
    logic         c_q, c_d;
    logic         err_q, err_d;

    logic         grant_vld;
    logic         gsel;
    logic         accept;
    logic [W:0]   sum9;
    logic [W:0]   diff9;

    // Tie goes to whichever requester was not granted last.
    always_comb begin
        grant_vld = |req_valid;
        if (&req_valid) begin
            gsel = ~last_grant_q;
        end else begin
            gsel = req_valid[1];
        end
        req_ready = '0;
        if (state_q == StIdle && grant_vld) begin
            req_ready[gsel] = 1'b1;
        end
        accept = |(req_valid & req_ready);
    end

    assign sum9  = {1'b0, a_q} + {1'b0, b_q};
    assign diff9 = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        z_d          = z_q;
        c_d          = c_q;
        err_d        = err_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d         = gsel ? req_op[5:3] : req_op[2:0];
                    a_d          = gsel ? req_a[W +: W] : req_a[0 +: W];
                    b_d          = gsel ? req_b[W +: W] : req_b[0 +: W];
                    id_d         = gsel;
                    last_grant_d = gsel;
                    state_d      = StExec;
                end
            end
            StExec: begin
                z_d   = '0;
                c_d   = 1'b0;
                err_d = 1'b0;
                unique case (op_q)
                    OpAnd:   z_d = a_q & b_q;
                    OpOr:    z_d = a_q | b_q;
                    OpXor:   z_d = a_q ^ b_q;
                    OpAdd:   {c_d, z_d} = sum9;
                    OpSub:   {c_d, z_d} = diff9;
                    OpNot:   z_d = ~a_q;
                    default: err_d = 1'b1;
                endcase
                state_d = StDone;
            end
            StDone: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            z_q          <= '0;
            c_q          <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            z_q          <= z_d;
            c_q          <= c_d;
            err_q        <= err_d;
        end
    end

    assign rsp_valid = (state_q == StDone);
    assign rsp_id    = id_q;
    assign rsp_z     = z_q;
    assign rsp_c     = c_q;
    assign rsp_err   = err_q;

`ifdef ALU8_SCHED_STATS_EN
    logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    // Saturating accept counters; illegal ops count as accepts.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (accept && !gsel && cnt0_q != 16'hFFFF) cnt0_d = cnt0_q + 16'd1;
        if (accept && gsel && cnt1_q != 16'hFFFF)  cnt1_d = cnt1_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign stat_cnt = {cnt1_q, cnt0_q};
`else
    assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_alu8_sched.sv
// Randomized self-checking bench for alu8_sched against a behavioural op/arbiter model.
// Build with ALU8_SCHED_STATS_EN defined to also check the accept counters.
module tb_alu8_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [5:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [7:0]  rsp_z;
    logic        rsp_c;
    logic        rsp_err;
    logic [31:0] stat_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int last_g;
    int exp_cnt[2];

    alu8_sched dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_z     (rsp_z),
        .rsp_c     (rsp_c),
        .rsp_err   (rsp_err),
        .stat_cnt  (stat_cnt)
    );

    always #5 clk = ~clk;

    // Returns {err, c, z[7:0]} from plain integer arithmetic.
    function automatic logic [9:0] alu_ref(input int op, input int a, input int b);
        int z;
        logic c;
        logic e;
        z = 0;
        c = 1'b0;
        e = 1'b0;
        case (op)
            0: z = a & b;
            1: z = a | b;
            2: z = a ^ b;
            3: begin z = (a + b) % 256; c = (a + b) > 255; end
            4: begin z = (a - b + 256) % 256; c = a < b; end
            5: z = 255 - a;
            default: e = 1'b1;
        endcase
        return {e, c, z[7:0]};
    endfunction

    function automatic logic [31:0] exp_stat();
`ifdef ALU8_SCHED_STATS_EN
        int c0;
        int c1;
        c0 = (exp_cnt[0] > 65535) ? 65535 : exp_cnt[0];
        c1 = (exp_cnt[1] > 65535) ? 65535 : exp_cnt[1];
        return {c1[15:0], c0[15:0]};
`else
        return 32'h0;
`endif
    endfunction

    function automatic logic [1:0] onehot(input int id);
        return (id == 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic set_req(input int id, input int op, input int a, input int b);
        req_op[id*3 +: 3] = 3'(op);
        req_a[id*8 +: 8]  = 8'(a);
        req_b[id*8 +: 8]  = 8'(b);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = 2'b00;
        rsp_ready  = 1'b0;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        last_g     = 1;
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One transaction: request, accept, EXEC, DONE, handoff, all checked against the model.
    task automatic run_op(input int id, input int op, input int a, input int b, input string tag);
        logic [9:0]  e;
        logic [11:0] exp_rsp;
        e       = alu_ref(op, a, b);
        exp_rsp = {1'b1, 1'(id), e[9], e[8], e[7:0]};
        @(negedge clk);
        set_req(id, op, a, b);
        req_valid = onehot(id);
        #1;
        n_checks++;
        if (req_ready !== onehot(id)) begin
            n_fail++;
            $display("FAIL %s accept: req_ready=%b expected %b", tag, req_ready, onehot(id));
        end
        @(negedge clk);
        req_valid = 2'b00;
        last_g = id;
        exp_cnt[id]++;
        #1;
        n_checks++;
        if ({rsp_valid, req_ready} !== 3'b000) begin
            n_fail++;
            $display("FAIL %s exec: rsp_valid,req_ready=%b expected 000", tag, {rsp_valid, req_ready});
        end
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_err, rsp_c, rsp_z} !== exp_rsp) begin
            n_fail++;
            $display("FAIL %s rsp: {valid,id,err,c,z}=%h expected %h", tag,
                     {rsp_valid, rsp_id, rsp_err, rsp_c, rsp_z}, exp_rsp);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s handoff: rsp_valid=%b expected 0", tag, rsp_valid);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_id, rsp_z, rsp_c, rsp_err} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset outputs: %h expected 0",
                     {req_ready, rsp_valid, rsp_id, rsp_z, rsp_c, rsp_err});
        end
        n_checks++;
        if (stat_cnt !== 32'h0) begin
            n_fail++;
            $display("FAIL reset stat_cnt: %h expected 0", stat_cnt);
        end
    endtask

    task automatic test_basic();
        run_op(0, 0, 'h12, 'h45, "and0");
        run_op(0, 0, 'h16, 'h55, "and1");
        run_op(1, 3, 'hFF, 'h01, "add_carry");
        run_op(1, 4, 'h05, 'h07, "sub_borrow");
        run_op(1, 4, 'h07, 'h05, "sub_noborrow");
        run_op(0, 5, 'h3C, 'h00, "not");
    endtask

    task automatic test_illegal();
        run_op(0, 6, 'hAA, 'h55, "illegal6");
        run_op(1, 1, 'hA0, 'h0F, "or_after_illegal");
        run_op(1, 7, 'h11, 'h22, "illegal7");
        @(negedge clk);
        n_checks++;
        if (stat_cnt !== exp_stat()) begin
            n_fail++;
            $display("FAIL illegal stat_cnt: %h expected %h", stat_cnt, exp_stat());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            run_op(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), "random");
        end
        @(negedge clk);
        n_checks++;
        if (stat_cnt !== exp_stat()) begin
            n_fail++;
            $display("FAIL random stat_cnt: %h expected %h", stat_cnt, exp_stat());
        end
    endtask

    task automatic test_back_to_back();
        int         acc;
        int         nrsp;
        int         g;
        int         q[$];
        int         a0, b0, a1, b1;
        logic [9:0] e;
        do_reset();
        a0 = int'($urandom_range(0, 255));
        b0 = int'($urandom_range(0, 255));
        a1 = int'($urandom_range(0, 255));
        b1 = int'($urandom_range(0, 255));
        set_req(0, 3, a0, b0);
        set_req(1, 4, a1, b1);
        acc  = 0;
        nrsp = 0;
        @(negedge clk);
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && nrsp < 4; cyc++) begin
            #1;
            if (req_ready !== 2'b00) begin
                g = (last_g == 1) ? 0 : 1;
                n_checks++;
                if (req_ready !== onehot(g)) begin
                    n_fail++;
                    $display("FAIL b2b grant %0d: req_ready=%b expected %b", acc, req_ready, onehot(g));
                end
                q.push_back(g);
                last_g = g;
                exp_cnt[g]++;
                acc++;
            end
            if (rsp_valid === 1'b1) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b spurious response: rsp_id=%b expected none", rsp_id);
                end else begin
                    g = q.pop_front();
                    e = (g == 0) ? alu_ref(3, a0, b0) : alu_ref(4, a1, b1);
                    if ({rsp_id, rsp_err, rsp_c, rsp_z} !== {1'(g), e}) begin
                        n_fail++;
                        $display("FAIL b2b rsp %0d: {id,err,c,z}=%h expected %h", nrsp,
                                 {rsp_id, rsp_err, rsp_c, rsp_z}, {1'(g), e});
                    end
                end
                nrsp++;
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        n_checks++;
        if (nrsp != 4) begin
            n_fail++;
            $display("FAIL b2b timeout: responses=%0d expected 4", nrsp);
        end
        @(negedge clk);
        n_checks++;
        if (stat_cnt !== exp_stat()) begin
            n_fail++;
            $display("FAIL b2b stat_cnt: %h expected %h", stat_cnt, exp_stat());
        end
    endtask

    task automatic test_stall();
        logic [9:0] e;
        int         a;
        int         b;
        a = int'($urandom_range(0, 255));
        b = int'($urandom_range(0, 255));
        e = alu_ref(2, a, b);
        @(negedge clk);
        set_req(1, 2, a, b);
        set_req(0, 1, 'h01, 'h02);
        req_valid = 2'b10;
        @(negedge clk);
        last_g = 1;
        exp_cnt[1]++;
        req_valid = 2'b11;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if ({rsp_valid, rsp_id, rsp_z, req_ready} !== {2'b11, e[7:0], 2'b00}) begin
                n_fail++;
                $display("FAIL stall cycle %0d: {valid,id,z,ready}=%h expected %h", i,
                         {rsp_valid, rsp_id, rsp_z, req_ready}, {2'b11, e[7:0], 2'b00});
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        n_checks++;
        if ({rsp_valid, req_ready} !== {1'b0, onehot(0)}) begin
            n_fail++;
            $display("FAIL stall release: {valid,ready}=%b expected %b",
                     {rsp_valid, req_ready}, {1'b0, onehot(0)});
        end
        req_valid = 2'b00;
    endtask

    task automatic test_reset_midop();
        int seen;
        do_reset();
        run_op(1, 0, 'hF0, 'h3C, "pre_reset");
        @(negedge clk);
        set_req(0, 3, 'h10, 'h20);
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_id, rsp_z, rsp_c, rsp_err, stat_cnt} !== 45'h0) begin
            n_fail++;
            $display("FAIL midop reset outputs: %h expected 0",
                     {req_ready, rsp_valid, rsp_id, rsp_z, rsp_c, rsp_err, stat_cnt});
        end
        @(negedge clk);
        rst = 1'b0;
        last_g = 1;
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        rsp_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) seen++;
        end
        rsp_ready = 1'b0;
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL midop stale response: rsp_valid cycles=%0d expected 0", seen);
        end
        set_req(1, 1, 'h01, 'h02);
        req_valid = 2'b11;
        #1;
        n_checks++;
        if (req_ready !== onehot(0)) begin
            n_fail++;
            $display("FAIL midop tie: req_ready=%b expected %b", req_ready, onehot(0));
        end
        req_valid = 2'b00;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_illegal();
        test_random();
        test_back_to_back();
        test_stall();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
